// File: rtl/alu_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_if
//   Bundles every non-clock/reset signal of alu_share_arbiter:
//     - two request channels   (reqN_valid_i / reqN_ready_o / operands / ctrl)
//     - two response channels  (rspN_valid_o / rspN_ready_i / result / zero / err)
//     - the shared ALU hookup  (alu_src1_o / alu_src2_o / alu_ctrl_o,
//                               alu_result_i / alu_zero_i)
//     - busy_o status
//   Signal suffixes are from the arbiter's point of view.
//   Modports:
//     slave  - the arbiter itself
//     master - requesters, response consumers and the ALU (the environment)
//   WIDTH must match the WIDTH of the arbiter it is bound to.
// -----------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    // request channels
    logic             req0_valid_i;
    logic             req0_ready_o;
    logic [WIDTH-1:0] req0_src1_i;
    logic [WIDTH-1:0] req0_src2_i;
    logic [3:0]       req0_ctrl_i;
    logic             req1_valid_i;
    logic             req1_ready_o;
    logic [WIDTH-1:0] req1_src1_i;
    logic [WIDTH-1:0] req1_src2_i;
    logic [3:0]       req1_ctrl_i;

    // response channels
    logic             rsp0_valid_o;
    logic             rsp0_ready_i;
    logic [WIDTH-1:0] rsp0_result_o;
    logic             rsp0_zero_o;
    logic             rsp0_err_o;
    logic             rsp1_valid_o;
    logic             rsp1_ready_i;
    logic [WIDTH-1:0] rsp1_result_o;
    logic             rsp1_zero_o;
    logic             rsp1_err_o;

    // shared ALU
    logic [WIDTH-1:0] alu_src1_o;
    logic [WIDTH-1:0] alu_src2_o;
    logic [3:0]       alu_ctrl_o;
    logic [WIDTH-1:0] alu_result_i;
    logic             alu_zero_i;

    logic             busy_o;

    modport slave (
        input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
        input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
        output req0_ready_o, req1_ready_o,
        input  rsp0_ready_i, rsp1_ready_i,
        output rsp0_valid_o, rsp0_result_o, rsp0_zero_o, rsp0_err_o,
        output rsp1_valid_o, rsp1_result_o, rsp1_zero_o, rsp1_err_o,
        output alu_src1_o, alu_src2_o, alu_ctrl_o,
        input  alu_result_i, alu_zero_i,
        output busy_o
    );

    modport master (
        output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
        output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
        input  req0_ready_o, req1_ready_o,
        output rsp0_ready_i, rsp1_ready_i,
        input  rsp0_valid_o, rsp0_result_o, rsp0_zero_o, rsp0_err_o,
        input  rsp1_valid_o, rsp1_result_o, rsp1_zero_o, rsp1_err_o,
        input  alu_src1_o, alu_src2_o, alu_ctrl_o,
        output alu_result_i, alu_zero_i,
        input  busy_o
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one ALU between port 0 (integer op queue) and port 1 (debug /
//   self-test). Round-robin grant in IDLE, operands latched on accept, ALU
//   driven for ALU_LAT cycles, result/zero returned on the owner's response
//   channel. Illegal control codes are answered directly (err=1, result=0,
//   zero=1) without touching the ALU.
//
//   Parameters:
//     WIDTH   - operand/result width
//     ALU_LAT - edges between accept and sampling the ALU result (1..15)
//   Ports:
//     clk_i   - clock, rising edge
//     rst_i   - synchronous active-high reset; aborts any op in flight
//     bus     - alu_share_arbiter_if.slave (requests, responses, ALU, busy_o)
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // cnt is 4 bits, so ALU_LAT is only meaningful in 1..15
    localparam logic [3:0] LAT = 4'(ALU_LAT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner;
    logic                  r_last_grant;
    logic [3:0]            r_cnt;
    logic [WIDTH-1:0]      r_src1;
    logic [WIDTH-1:0]      r_src2;
    logic [3:0]            r_ctrl;
    // Result registers are kept per port so a port's outputs hold their last
    // value while the other port is being served.
    logic [1:0][WIDTH-1:0] r_res;
    logic [1:0]            r_zf;
    logic [1:0]            r_err;

    logic                  w_grant;
    logic                  w_ready0;
    logic                  w_ready1;
    logic                  w_acc;
    logic                  w_acc_legal;
    logic [WIDTH-1:0]      w_acc_src1;
    logic [WIDTH-1:0]      w_acc_src2;
    logic [3:0]            w_acc_ctrl;
    logic                  w_rsp_hs;

    function automatic logic ctrl_legal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0110, 4'b0111, 4'b1000, 4'b1001,
            4'b1100: ctrl_legal = 1'b1;
            default: ctrl_legal = 1'b0;
        endcase
    endfunction

    // Round robin: a lone requester wins; on contention the port that was
    // not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid_i && bus.req1_valid_i)
            w_grant = ~r_last_grant;
        else if (bus.req1_valid_i)
            w_grant = 1'b1;
    end

    always_comb begin
        w_ready0    = (r_state == S_IDLE) && bus.req0_valid_i && !w_grant;
        w_ready1    = (r_state == S_IDLE) && bus.req1_valid_i &&  w_grant;
        w_acc       = w_ready0 || w_ready1;
        w_acc_src1  = w_grant ? bus.req1_src1_i : bus.req0_src1_i;
        w_acc_src2  = w_grant ? bus.req1_src2_i : bus.req0_src2_i;
        w_acc_ctrl  = w_grant ? bus.req1_ctrl_i : bus.req0_ctrl_i;
        w_acc_legal = ctrl_legal(w_acc_ctrl);
        // only the owner's ready can release the response
        w_rsp_hs    = (r_state == S_RESP) &&
                      (r_owner ? bus.rsp1_ready_i : bus.rsp0_ready_i);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_acc) w_state_nxt = w_acc_legal ? S_EXEC : S_RESP;
            S_EXEC: if (r_cnt == 4'd1) w_state_nxt = S_RESP;
            S_RESP: if (w_rsp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_ctrl       <= 4'd0;
            r_res        <= '0;
            r_zf         <= 2'b00;
            r_err        <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_owner <= w_grant;
                        if (w_acc_legal) begin
                            r_src1 <= w_acc_src1;
                            r_src2 <= w_acc_src2;
                            r_ctrl <= w_acc_ctrl;
                            r_cnt  <= LAT;
                        end else begin
                            // answered without the ALU; its inputs keep the
                            // previous op
                            r_res[w_grant] <= '0;
                            r_zf[w_grant]  <= 1'b1;
                            r_err[w_grant] <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_res[r_owner] <= bus.alu_result_i;
                        r_zf[r_owner]  <= bus.alu_zero_i;
                        r_err[r_owner] <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) r_last_grant <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready_o  = w_ready0;
    assign bus.req1_ready_o  = w_ready1;

    assign bus.rsp0_valid_o  = (r_state == S_RESP) && !r_owner;
    assign bus.rsp1_valid_o  = (r_state == S_RESP) &&  r_owner;
    assign bus.rsp0_result_o = r_res[0];
    assign bus.rsp0_zero_o   = r_zf[0];
    assign bus.rsp0_err_o    = r_err[0];
    assign bus.rsp1_result_o = r_res[1];
    assign bus.rsp1_zero_o   = r_zf[1];
    assign bus.rsp1_err_o    = r_err[1];

    assign bus.alu_src1_o    = r_src1;
    assign bus.alu_src2_o    = r_src2;
    assign bus.alu_ctrl_o    = r_ctrl;

    assign bus.busy_o        = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [1:0]    v   = 2'b00;
    logic [1:0]    rr  = 2'b00;
    logic [W-1:0]  s1 [2] = '{32'd0, 32'd0};
    logic [W-1:0]  s2 [2] = '{32'd0, 32'd0};
    logic [3:0]    c  [2] = '{4'd0, 4'd0};

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] legal_tbl [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12};

    // observed outputs, index [dut][port]; dut 0 has ALU_LAT=1, dut 1 ALU_LAT=3
    logic [1:0][1:0]        o_ready, o_rv, o_zero, o_err;
    logic [1:0][1:0][W-1:0] o_res;
    logic [1:0][W-1:0]      o_a1, o_a2;
    logic [1:0][3:0]        o_ac;
    logic [1:0]             o_busy;

    // behavioural ALU (environment) and the op table used by the model
    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'd0:    alu_fn = a & b;
            4'd1:    alu_fn = a | b;
            4'd2:    alu_fn = a + b;
            4'd3:    alu_fn = a ^ b;
            4'd6:    alu_fn = a - b;
            4'd7:    alu_fn = {31'd0, $signed(a) < $signed(b)};
            4'd8:    alu_fn = a >> b[4:0];
            4'd9:    alu_fn = $unsigned($signed(a) >>> b[4:0]);
            4'd12:   alu_fn = a << b[4:0];
            default: alu_fn = '0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        is_legal = 1'b0;
        for (int i = 0; i < 9; i++) if (legal_tbl[i] == op) is_legal = 1'b1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LATG = (g == 0) ? 1 : 3;
        alu_share_arbiter_if #(.WIDTH(W)) bus_if ();

        assign bus_if.req0_valid_i = v[0];
        assign bus_if.req0_src1_i  = s1[0];
        assign bus_if.req0_src2_i  = s2[0];
        assign bus_if.req0_ctrl_i  = c[0];
        assign bus_if.req1_valid_i = v[1];
        assign bus_if.req1_src1_i  = s1[1];
        assign bus_if.req1_src2_i  = s2[1];
        assign bus_if.req1_ctrl_i  = c[1];
        assign bus_if.rsp0_ready_i = rr[0];
        assign bus_if.rsp1_ready_i = rr[1];
        assign bus_if.alu_result_i = alu_fn(bus_if.alu_ctrl_o, bus_if.alu_src1_o, bus_if.alu_src2_o);
        assign bus_if.alu_zero_i   = (bus_if.alu_result_i == '0);

        assign o_ready[g] = {bus_if.req1_ready_o, bus_if.req0_ready_o};
        assign o_rv[g]    = {bus_if.rsp1_valid_o, bus_if.rsp0_valid_o};
        assign o_zero[g]  = {bus_if.rsp1_zero_o, bus_if.rsp0_zero_o};
        assign o_err[g]   = {bus_if.rsp1_err_o, bus_if.rsp0_err_o};
        assign o_res[g]   = {bus_if.rsp1_result_o, bus_if.rsp0_result_o};
        assign o_a1[g]    = bus_if.alu_src1_o;
        assign o_a2[g]    = bus_if.alu_src2_o;
        assign o_ac[g]    = bus_if.alu_ctrl_o;
        assign o_busy[g]  = bus_if.busy_o;

        alu_share_arbiter #(.WIDTH(W), .ALU_LAT(LATG)) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus_if)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; v = 2'b00; rr = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_op(input logic n, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        c[n] = op; s1[n] = a; s2[n] = b;
    endtask

    task automatic test_reset();
        logic d;
        rst = 1'b1; v = 2'b00; rr = 2'b00;
        tick(); #1;
        for (int i = 0; i < 2; i++) begin
            d = i[0];
            n_total++;
            if ({o_ready[d], o_rv[d], o_busy[d], o_a1[d], o_a2[d], o_ac[d], o_res[d], o_zero[d], o_err[d]} !== '0)
                $display("FAIL reset_state dut%0d got ready=%b rv=%b busy=%b alu=%h/%h/%h res=%h zero=%b err=%b want all 0",
                         i, o_ready[d], o_rv[d], o_busy[d], o_a1[d], o_a2[d], o_ac[d], o_res[d], o_zero[d], o_err[d]);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        do_reset();
        rr = 2'b01; v = 2'b01; set_op(1'b0, 4'b0010, 32'd5, 32'd7);
        #1;
        n_total++; if (o_ready[0] !== 2'b01) $display("FAIL add_ready got %b want 01", o_ready[0]); else n_pass++;
        tick(); v = 2'b00; #1;
        n_total++; if (o_ready[0] !== 2'b00) $display("FAIL add_ready_drop got %b want 00", o_ready[0]); else n_pass++;
        n_total++; if ({o_rv[0], o_busy[0]} !== 3'b001) $display("FAIL add_exec got rv=%b busy=%b want rv=00 busy=1", o_rv[0], o_busy[0]); else n_pass++;
        n_total++; if ({o_a1[0], o_a2[0], o_ac[0]} !== {32'd5, 32'd7, 4'b0010})
            $display("FAIL add_alu_drive got %h/%h/%h want 5/7/2", o_a1[0], o_a2[0], o_ac[0]); else n_pass++;
        tick(); #1;
        n_total++; if (o_rv[0] !== 2'b01) $display("FAIL add_rsp_valid got %b want 01", o_rv[0]); else n_pass++;
        n_total++; if ({o_res[0][0], o_zero[0][0], o_err[0][0]} !== {32'd12, 1'b0, 1'b0})
            $display("FAIL add_rsp_data got res=%0d zero=%b err=%b want 12/0/0", o_res[0][0], o_zero[0][0], o_err[0][0]); else n_pass++;
        tick(); #1;
        n_total++; if ({o_busy[0], o_rv[0]} !== 3'b000) $display("FAIL add_release got busy=%b rv=%b want 0/00", o_busy[0], o_rv[0]); else n_pass++;
        n_total++; if (o_res[0][0] !== 32'd12) $display("FAIL add_res_hold got %0d want 12", o_res[0][0]); else n_pass++;
        rr = 2'b00;
    endtask

    task automatic test_alternate();
        logic exp_p = 1'b0;
        int grants = 0;
        do_reset();
        set_op(1'b0, 4'b0110, 32'd9, 32'd9);
        set_op(1'b1, 4'b0011, 32'hF0, 32'h0F);
        v = 2'b11; rr = 2'b11;
        for (int t = 0; t < 15; t++) begin
            #1;
            n_total++; if (o_ready[0] === 2'b11) $display("FAIL alt_double_grant cyc%0d got 11 want one-hot or 00", t); else n_pass++;
            if (o_ready[0] !== 2'b00) begin
                n_total++;
                if (o_ready[0] !== (exp_p ? 2'b10 : 2'b01)) $display("FAIL alt_grant_order cyc%0d got %b want port %0d", t, o_ready[0], exp_p);
                else n_pass++;
                exp_p = ~exp_p; grants++;
            end
            if (o_rv[0][0]) begin
                n_total++; if ({o_res[0][0], o_zero[0][0]} !== {32'd0, 1'b1})
                    $display("FAIL alt_p0_data got %h/%b want 0/1", o_res[0][0], o_zero[0][0]); else n_pass++;
            end
            if (o_rv[0][1]) begin
                n_total++; if ({o_res[0][1], o_zero[0][1]} !== {32'hFF, 1'b0})
                    $display("FAIL alt_p1_data got %h/%b want ff/0", o_res[0][1], o_zero[0][1]); else n_pass++;
            end
            tick();
        end
        n_total++; if (grants != 5) $display("FAIL alt_grant_count got %0d want 5", grants); else n_pass++;
        v = 2'b00; rr = 2'b00;
    endtask

    task automatic test_lat3_stall();
        do_reset();
        rr = 2'b00; v = 2'b10; set_op(1'b1, 4'b1100, 32'd1, 32'd4);
        #1;
        n_total++; if (o_ready[1] !== 2'b10) $display("FAIL lat3_ready got %b want 10", o_ready[1]); else n_pass++;
        tick(); v = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) rr = 2'b10;
            #1;
            n_total++; if (o_rv[1] !== ((k >= 4) ? 2'b10 : 2'b00))
                $display("FAIL lat3_rsp_valid k%0d got %b want %b", k, o_rv[1], (k >= 4) ? 2'b10 : 2'b00); else n_pass++;
            n_total++; if ({o_a1[1], o_a2[1], o_ac[1]} !== {32'd1, 32'd4, 4'b1100})
                $display("FAIL lat3_alu_stable k%0d got %h/%h/%h want 1/4/c", k, o_a1[1], o_a2[1], o_ac[1]); else n_pass++;
            if (k >= 4) begin
                n_total++; if ({o_res[1][1], o_zero[1][1], o_err[1][1]} !== {32'd16, 1'b0, 1'b0})
                    $display("FAIL lat3_rsp_hold k%0d got %0d/%b/%b want 16/0/0", k, o_res[1][1], o_zero[1][1], o_err[1][1]); else n_pass++;
            end
            tick();
        end
        #1;
        n_total++; if ({o_busy[1], o_rv[1]} !== 3'b000) $display("FAIL lat3_release got busy=%b rv=%b want 0/00", o_busy[1], o_rv[1]); else n_pass++;
        rr = 2'b00;
    endtask

    task automatic test_illegal();
        do_reset();
        rr = 2'b01; v = 2'b01; set_op(1'b0, 4'b0000, 32'hA5, 32'h0F);
        tick(); v = 2'b00; tick(); tick();
        v = 2'b01; set_op(1'b0, 4'b1111, 32'd123, 32'd456);
        #1;
        n_total++; if (o_ready[0] !== 2'b01) $display("FAIL ill_ready got %b want 01", o_ready[0]); else n_pass++;
        tick(); v = 2'b00; #1;
        n_total++; if (o_rv[0] !== 2'b01) $display("FAIL ill_rsp_valid got %b want 01", o_rv[0]); else n_pass++;
        n_total++; if ({o_res[0][0], o_zero[0][0], o_err[0][0]} !== {32'd0, 1'b1, 1'b1})
            $display("FAIL ill_rsp_data got %h/%b/%b want 0/1/1", o_res[0][0], o_zero[0][0], o_err[0][0]); else n_pass++;
        n_total++; if ({o_a1[0], o_a2[0], o_ac[0]} !== {32'hA5, 32'h0F, 4'b0000})
            $display("FAIL ill_alu_kept got %h/%h/%h want a5/f/0", o_a1[0], o_a2[0], o_ac[0]); else n_pass++;
        tick(); #1;
        n_total++; if ({o_busy[0], o_rv[0]} !== 3'b000) $display("FAIL ill_release got busy=%b rv=%b want 0/00", o_busy[0], o_rv[0]); else n_pass++;
        rr = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rr = 2'b01; v = 2'b01; set_op(1'b0, 4'b0010, 32'd2, 32'd3);
        tick(); v = 2'b00; tick(); tick();
        v = 2'b01; set_op(1'b0, 4'b0010, 32'd4, 32'd4);
        tick(); v = 2'b00; #1;
        n_total++; if (o_busy[0] !== 1'b1) $display("FAIL rstmid_busy got %b want 1", o_busy[0]); else n_pass++;
        rst = 1'b1; tick(); rst = 1'b0; #1;
        n_total++;
        if ({o_ready[0], o_rv[0], o_busy[0], o_a1[0], o_a2[0], o_ac[0], o_res[0], o_zero[0], o_err[0]} !== '0)
            $display("FAIL rstmid_state got ready=%b rv=%b busy=%b alu=%h/%h/%h res=%h want all 0",
                     o_ready[0], o_rv[0], o_busy[0], o_a1[0], o_a2[0], o_ac[0], o_res[0]);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            n_total++; if (o_rv[0] !== 2'b00) $display("FAIL rstmid_no_rsp k%0d got %b want 00", k, o_rv[0]); else n_pass++;
        end
        v = 2'b11; set_op(1'b1, 4'b0001, 32'd1, 32'd2);
        #1;
        n_total++; if (o_ready[0] !== 2'b01) $display("FAIL rstmid_grant got %b want 01", o_ready[0]); else n_pass++;
        v = 2'b00; rr = 2'b00;
    endtask

    task automatic test_nonowner();
        do_reset();
        rr = 2'b10; v = 2'b01; set_op(1'b0, 4'b0010, 32'd1, 32'd1);
        tick();
        v = 2'b10; set_op(1'b1, 4'b0001, 32'd3, 32'd4);
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_total++; if (o_ready[0] !== 2'b00) $display("FAIL nonown_ready k%0d got %b want 00", k, o_ready[0]); else n_pass++;
            if (k >= 2) begin
                n_total++; if (o_rv[0] !== 2'b01) $display("FAIL nonown_rsp_hold k%0d got %b want 01", k, o_rv[0]); else n_pass++;
            end
            tick();
        end
        rr = 2'b11; #1;
        n_total++; if (o_ready[0] !== 2'b00) $display("FAIL nonown_release_cycle got %b want 00", o_ready[0]); else n_pass++;
        tick(); #1;
        n_total++; if (o_ready[0] !== 2'b10) $display("FAIL nonown_p1_grant got %b want 10", o_ready[0]); else n_pass++;
        tick(); v = 2'b00; tick(); #1;
        n_total++; if ({o_rv[0], o_res[0][1]} !== {2'b10, 32'd7})
            $display("FAIL nonown_p1_rsp got rv=%b res=%0d want 10/7", o_rv[0], o_res[0][1]); else n_pass++;
        tick(); rr = 2'b00;
    endtask

    // Transaction-level model: one op outstanding at a time, round-robin by
    // last served port, response due L edges after accept (0 for illegal).
    task automatic test_random(input logic d);
        logic outst, own, last, g, op_legal, n;
        int   wt, lat;
        logic [W-1:0] e_res, op_a, op_b;
        logic [3:0]   op_c;
        logic         e_z, e_err;
        logic [1:0]   e_ready, e_rv, acc;
        outst = 1'b0; own = 1'b0; last = 1'b1; op_legal = 1'b0; wt = 0;
        e_res = '0; op_a = '0; op_b = '0; op_c = '0; e_z = 1'b0; e_err = 1'b0;
        lat = d ? 3 : 1;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                n = i[0];
                if (!v[n] && ($urandom % 3 == 0)) begin
                    v[n]  = 1'b1;
                    s1[n] = $urandom;
                    s2[n] = ($urandom % 4 == 0) ? s1[n] : $urandom;
                    c[n]  = ($urandom % 5 == 0) ? 4'($urandom) : legal_tbl[$urandom % 9];
                end
                rr[n] = ($urandom % 4) != 0;
            end
            #1;
            g       = (v == 2'b11) ? ~last : v[1];
            e_ready = (!outst && v != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
            e_rv    = (outst && wt == 0) ? (own ? 2'b10 : 2'b01) : 2'b00;
            n_total++; if (o_ready[d] !== e_ready) $display("FAIL rnd_ready dut%0d cyc%0d got %b want %b", d, cyc, o_ready[d], e_ready); else n_pass++;
            n_total++; if (o_rv[d] !== e_rv) $display("FAIL rnd_rsp_valid dut%0d cyc%0d got %b want %b", d, cyc, o_rv[d], e_rv); else n_pass++;
            n_total++; if (o_busy[d] !== outst) $display("FAIL rnd_busy dut%0d cyc%0d got %b want %b", d, cyc, o_busy[d], outst); else n_pass++;
            if (e_rv != 2'b00) begin
                n_total++;
                if ({o_res[d][own], o_zero[d][own], o_err[d][own]} !== {e_res, e_z, e_err})
                    $display("FAIL rnd_rsp_data dut%0d cyc%0d port%0d got %h/%b/%b want %h/%b/%b", d, cyc, own,
                             o_res[d][own], o_zero[d][own], o_err[d][own], e_res, e_z, e_err);
                else n_pass++;
            end
            if (outst && op_legal && wt > 0) begin
                n_total++;
                if ({o_a1[d], o_a2[d], o_ac[d]} !== {op_a, op_b, op_c})
                    $display("FAIL rnd_alu_drive dut%0d cyc%0d got %h/%h/%h want %h/%h/%h", d, cyc,
                             o_a1[d], o_a2[d], o_ac[d], op_a, op_b, op_c);
                else n_pass++;
            end
            acc = e_ready;
            if (e_ready != 2'b00) begin
                outst = 1'b1; own = g;
                op_a = s1[g]; op_b = s2[g]; op_c = c[g];
                op_legal = is_legal(op_c);
                wt    = op_legal ? lat : 0;
                e_res = op_legal ? alu_fn(op_c, op_a, op_b) : '0;
                e_z   = (e_res == '0);
                e_err = !op_legal;
            end else if (outst && wt > 0) begin
                wt--;
            end else if (outst && rr[own]) begin
                outst = 1'b0; last = own;
            end
            tick();
            v = v & ~acc;
        end
        v = 2'b00; rr = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_add();
        test_alternate();
        test_lat3_stall();
        test_illegal();
        test_reset_mid();
        test_nonowner();
        test_random(1'b0);
        test_random(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU instance between two requesters: IF/EX-side integer op queue (port 0) and a debug/self-test port (port 1).
- Arbitrates round-robin and latches operands.
- Drives the ALU for a fixed configurable latency, captures result/zero, and returns them on a per-requester valid/ready response channel.
- Screens illegal ALU control codes without occupying the ALU.

Parameters:
- WIDTH, 32, operand/result width.
- ALU_LAT, 1, clock cycles between driving alu_*_o and sampling alu_result_i/alu_zero_i; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- req0_valid_i  in  1  port-0 request valid
- req0_ready_o  out  1  port-0 request accepted this cycle
- req0_src1_i  in  WIDTH  port-0 operand 1
- req0_src2_i  in  WIDTH  port-0 operand 2
- req0_ctrl_i  in  4  port-0 ALU control code
- req1_valid_i, req1_ready_o, req1_src1_i, req1_src2_i, req1_ctrl_i: same as port 0, for port 1
- rsp0_valid_o  out  1  port-0 response valid
- rsp0_ready_i  in  1  port-0 response consumed
- rsp0_result_o  out  WIDTH  result
- rsp0_zero_o  out  1  result==0
- rsp0_err_o  out  1  illegal control code
- rsp1_valid_o, rsp1_ready_i, rsp1_result_o, rsp1_zero_o, rsp1_err_o: same as port 0, for port 1
- alu_src1_o  out  WIDTH  to ALU src1
- alu_src2_o  out  WIDTH  to ALU src2
- alu_ctrl_o  out  4  to ALU control
- alu_result_i  in  WIDTH  from ALU
- alu_zero_i  in  1  from ALU
- busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, RESP. Registers: owner (1b), last_grant (1b), cnt (4b), op regs (src1, src2, ctrl), res (WIDTH), zf, err.
- Reset, when rst_i=1 at an edge:
  - state=IDLE, last_grant=1 (port 0 favoured first), cnt=0.
  - All op/result regs 0; all *_valid_o, *_ready_o, busy_o, alu_*_o = 0.
  - Reset mid-operation aborts the op; no response is ever issued for it.
- Legal ctrl codes: 0000 and, 0001 or, 0010 add, 0011 xor, 0110 sub, 0111 slt, 1000 srl, 1001 sra, 1100 sll. All other codes are illegal.
- Grant, combinational, IDLE only:
  - Only one valid: grant it.
  - Both valid: grant ~last_grant.
  - reqN_ready_o = (state==IDLE) & reqN_valid_i & (grant==N). Never both high.
  - In EXEC/RESP both readies are 0.
- IDLE, on handshake (valid&ready) at an edge:
  - Latch src1/src2/ctrl and set owner=N.
  - Legal ctrl: state→EXEC, cnt=ALU_LAT.
  - Illegal ctrl: state→RESP directly, res=0, zf=1, err=1. ALU op regs are not updated.
- alu_src1_o/alu_src2_o/alu_ctrl_o are driven from the op regs. They are stable throughout EXEC and hold their last value otherwise.
- EXEC:
  - Each edge, cnt decrements.
  - At the edge where cnt==1: res=alu_result_i, zf=alu_zero_i, err=0, state→RESP.
  - Result is sampled exactly ALU_LAT edges after the accept edge.
- RESP:
  - rsp{owner}_valid_o=1. The other response valid is 0.
  - result/zero/err outputs are registered and held stable while valid & ~ready.
  - On rsp{owner}_ready_i=1 at an edge: last_grant=owner, state→IDLE.
  - No request is accepted in the release cycle. Minimum issue interval is ALU_LAT+2 cycles for legal ops and 2 cycles for illegal ops.
- Non-owner rspN_ready_i is ignored. A requester must hold valid and payload until ready; changes while waiting are not detected.
- rsp*_result_o/zero_o/err_o keep their last value when not valid (reset value 0).
- busy_o=1 in EXEC and RESP.

Test Plan:
- Reset, ALU_LAT=1, port 0 issues add 5+7 with rsp0_ready_i=1 → req0_ready_o=1 for one cycle; rsp0_valid_o rises 1 cycle after accept edge; result=12, zero=0, err=0; busy_o returns 0.
- Both ports valid continuously (p0 sub 9-9, p1 xor 0xF0^0x0F) with rsp readies held 1 → grants alternate p0,p1,p0,…; p0 result=0/zero=1; p1 result=0xFF; no double grant in any cycle.
- ALU_LAT=3, p1 sll 1<<4, rsp1_ready_i held 0 for 5 cycles → alu_*_o stable across EXEC; rsp1_valid_o asserted 3 cycles after accept; result=16 held stable until ready; then IDLE.
- p0 ctrl=4'b1111 → rsp0_valid_o asserted next cycle with err=1, result=0, zero=1; alu_*_o unchanged from previous op.
- rst_i pulsed during EXEC of a p0 op → next cycle all outputs 0, state IDLE; no rsp0_valid_o for the aborted op; next grant goes to p0 if both valid.
- In RESP, port 1 valid and non-owner rsp1_ready_i=1 → req1_ready_o stays 0; port 1 is granted only after the owner's response handshake.
